// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if: bus bundle between the VRAM arbiter and its clients
//   vga_*  : scan-out fetch (strobe/addr in, data/valid out)
//   cpu_*  : CPU load/store handshake (req/we/addr/wdata in, ack/rdata out)
//   ram_*  : single-port VRAM (en/we/addr/wdata out, rdata in)
//   slave  : arbiter side; master: clients plus RAM model side
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              vga_strobe;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    modport slave (
        input  vga_strobe, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vga_data, vga_valid, cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );
    modport master (
        output vga_strobe, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vga_data, vga_valid, cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one 512x8 VRAM port between VGA fetch and CPU load/store
//   clk            : system clock
//   rst            : asynchronous reset, active-high
//   bus            : vram_port_arbiter_if.slave (vga_*, cpu_*, ram_* signals)
//   perf_clr_i     : clears conflict_cnt_o (only with VRAM_ARB_PERF_EN)
//   conflict_cnt_o : saturating count of CPU cycles blocked by VGA (only with VRAM_ARB_PERF_EN)
// VGA fetches always win the port. CPU writes are posted through a FIFO and
// drained in free cycles; CPU reads wait for the FIFO to drain first.
module vram_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    vram_port_arbiter_if.slave   bus
`ifdef VRAM_ARB_PERF_EN
    ,
    input  logic                 perf_clr_i,
    output logic [15:0]          conflict_cnt_o
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, RD_ISSUE, RD_DATA} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ack_q, vga_pend_q, vga_valid_q;
    logic [DATA_W-1:0]  vga_data_q, rdata_q;
    logic               fifo_empty, fifo_full, push, pop, rd_slot, cpu_ack;

    assign fifo_empty = cnt_q == '0;
    assign fifo_full  = cnt_q == CNT_W'(FIFO_DEPTH);
    // Read data is forwarded straight from the RAM in RD_DATA so the ack lands 3 cycles after req.
    assign cpu_ack    = ack_q | (state_q == RD_DATA);
    assign rd_slot    = state_q == RD_ISSUE;
    assign push       = bus.cpu_req & bus.cpu_we & (state_q == IDLE) & ~fifo_full & ~cpu_ack;
    assign pop        = ~bus.vga_strobe & ~rd_slot & ~fifo_empty;

    assign bus.ram_en    = bus.vga_strobe | rd_slot | ~fifo_empty;
    assign bus.ram_we    = pop;
    assign bus.ram_addr  = bus.vga_strobe ? bus.vga_addr :
                           rd_slot        ? bus.cpu_addr :
                           ~fifo_empty    ? fifo_addr_q[rd_ptr_q] : '0;
    assign bus.ram_wdata = pop ? fifo_data_q[rd_ptr_q] : '0;

    assign bus.vga_data  = vga_data_q;
    assign bus.vga_valid = vga_valid_q;
    assign bus.cpu_ack   = cpu_ack;
    assign bus.cpu_rdata = (state_q == RD_DATA) ? bus.ram_rdata : rdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = (bus.cpu_req & ~bus.cpu_we & ~cpu_ack) ? DRAIN : IDLE;
            DRAIN:    state_d = fifo_empty ? RD_ISSUE : DRAIN;
            RD_ISSUE: state_d = bus.vga_strobe ? RD_ISSUE : RD_DATA;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            vga_pend_q  <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
            cnt_q       <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            ack_q       <= push;
            vga_pend_q  <= bus.vga_strobe;
            vga_valid_q <= vga_pend_q;
            if (vga_pend_q)
                vga_data_q <= bus.ram_rdata;
            if (state_q == RD_DATA)
                rdata_q <= bus.ram_rdata;
        end
    end

    // Storage needs no reset: occupancy and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.cpu_addr;
            fifo_data_q[wr_ptr_q] <= bus.cpu_wdata;
        end
    end

`ifdef VRAM_ARB_PERF_EN
    logic [15:0] conflict_q;
    logic        blocked;

    assign blocked        = bus.vga_strobe & (rd_slot | ~fifo_empty);
    assign conflict_cnt_o = conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflict_q <= '0;
        else if (perf_clr_i)
            conflict_q <= '0;
        else if (blocked && conflict_q != 16'hFFFF)
            conflict_q <= conflict_q + 16'd1;
    end
`endif
endmodule
